// File: rtl/gate_chk_pkg.sv
// Shared types and constants for the gate response checker: FSM states,
// standard two-input truth tables and the {x,y} index encoding.
package gate_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } chk_state_e;

  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;

  // Wide enough for any legal TIMEOUT (1..255).
  localparam int IDLE_W = 8;

  function automatic logic [1:0] vec_idx(input logic x, input logic y);
    return {x, y};
  endfunction

endpackage

// File: rtl/gate_response_checker_if.sv
// Sample/verdict bundle between a stimulus driver (master) and the checker (slave).
interface gate_response_checker_if #(parameter int ERR_W = 8);

  logic             start;
  logic             smp_valid;
  logic             smp_x;
  logic             smp_y;
  logic             smp_out;
  logic             smp_last;
  logic             busy;
  logic             done;
  logic             pass;
  logic             timeout;
  logic [ERR_W-1:0] err_cnt;
  logic [3:0]       cov;
  logic             first_err_vld;
  logic [1:0]       first_err_idx;

  modport master (
    output start, smp_valid, smp_x, smp_y, smp_out, smp_last,
    input  busy, done, pass, timeout, err_cnt, cov, first_err_vld, first_err_idx
  );

  modport slave (
    input  start, smp_valid, smp_x, smp_y, smp_out, smp_last,
    output busy, done, pass, timeout, err_cnt, cov, first_err_vld, first_err_idx
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         sat_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && !sat_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;
  assign sat_o = &cnt_q;

endmodule

// File: rtl/gate_response_checker.sv
// Checks sampled {x,y}/output pairs against truth table TT, tracks coverage,
// counts mismatches and registers a pass/fail verdict at the end of each run.
module gate_response_checker
  import gate_chk_pkg::*;
#(
  parameter logic [3:0] TT      = 4'b1000,
  parameter int         ERR_W   = 8,
  parameter int         TIMEOUT = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  gate_response_checker_if.slave bus
);

  localparam logic [IDLE_W-1:0] TO_TC = IDLE_W'(TIMEOUT - 1);

  chk_state_e        state_q, state_d;
  logic [3:0]        cov_q, cov_d;
  logic              fev_q, fev_d;
  logic [1:0]        fei_q, fei_d;
  logic              to_q, to_d;
  logic              pass_q, pass_d;

  logic              err_clr, err_inc, err_sat;
  logic [ERR_W-1:0]  err_cnt;
  logic              idle_clr, idle_inc, idle_sat;
  logic [IDLE_W-1:0] idle_cnt;

  logic [1:0]        idx;
  logic              mism;

  assign idx  = vec_idx(bus.smp_x, bus.smp_y);
  assign mism = bus.smp_out != TT[idx];

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (err_clr),
    .inc_i (err_inc),
    .cnt_o (err_cnt),
    .sat_o (err_sat)
  );

  sat_counter #(.W(IDLE_W)) u_idle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (idle_clr),
    .inc_i (idle_inc),
    .cnt_o (idle_cnt),
    .sat_o (idle_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cov_q   <= '0;
      fev_q   <= 1'b0;
      fei_q   <= '0;
      to_q    <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cov_q   <= cov_d;
      fev_q   <= fev_d;
      fei_q   <= fei_d;
      to_q    <= to_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cov_d    = cov_q;
    fev_d    = fev_q;
    fei_d    = fei_q;
    to_d     = to_q;
    pass_d   = pass_q;
    err_clr  = 1'b0;
    err_inc  = 1'b0;
    idle_clr = 1'b0;
    idle_inc = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d  = ST_ACTIVE;
          cov_d    = '0;
          fev_d    = 1'b0;
          fei_d    = '0;
          to_d     = 1'b0;
          pass_d   = 1'b0;
          err_clr  = 1'b1;
          idle_clr = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (bus.smp_valid) begin
          cov_d[idx] = 1'b1;
          idle_clr   = 1'b1;
          if (mism) begin
            err_inc = 1'b1;
            if (!fev_q) begin
              fev_d = 1'b1;
              fei_d = idx;
            end
          end
          // Verdict must include the sample arriving with smp_last.
          if (bus.smp_last) begin
            state_d = ST_DONE;
            pass_d  = (err_cnt == '0) && !mism && !err_sat && (cov_d == 4'hF);
          end
        end else begin
          idle_inc = 1'b1;
          if (idle_cnt == TO_TC || idle_sat) begin
            state_d = ST_DONE;
            to_d    = 1'b1;
            pass_d  = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.busy          = state_q == ST_ACTIVE;
  assign bus.done          = state_q == ST_DONE;
  assign bus.pass          = pass_q;
  assign bus.timeout       = to_q;
  assign bus.err_cnt       = err_cnt;
  assign bus.cov           = cov_q;
  assign bus.first_err_vld = fev_q;
  assign bus.first_err_idx = fei_q;

endmodule

// File: tb/tb_gate_response_checker.sv
// Random and directed runs on two checker instances (AND/8-bit/16 and XOR/2-bit/5),
// each compared every cycle against a run-level behavioural model.
module tb_gate_response_checker;
  import gate_chk_pkg::*;

  typedef struct {
    int         mode;   // 0 idle, 1 running, 2 finished
    int         err;
    logic [3:0] cov;
    logic       fev;
    logic [1:0] fei;
    logic       to;
    int         idle;
    logic       pass;
  } model_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, v = 1'b0, x = 1'b0, y = 1'b0, o = 1'b0, last = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   chk_en = 1'b0;
  model_t m0, m1;

  always #5 clk = ~clk;

  gate_response_checker_if #(.ERR_W(8)) if0 ();
  gate_response_checker_if #(.ERR_W(2)) if1 ();

  assign if0.start = start;  assign if1.start = start;
  assign if0.smp_valid = v;  assign if1.smp_valid = v;
  assign if0.smp_x = x;      assign if1.smp_x = x;
  assign if0.smp_y = y;      assign if1.smp_y = y;
  assign if0.smp_out = o;    assign if1.smp_out = o;
  assign if0.smp_last = last; assign if1.smp_last = last;

  gate_response_checker #(.TT(TT_AND), .ERR_W(8), .TIMEOUT(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave));
  gate_response_checker #(.TT(TT_XOR), .ERR_W(2), .TIMEOUT(5)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave));

  function automatic model_t model_clear();
    model_t m;
    m.mode = 0; m.err = 0; m.cov = '0; m.fev = 0; m.fei = '0;
    m.to = 0; m.idle = 0; m.pass = 0;
    return m;
  endfunction

  // One clock edge of a run, from the rules: what a sample does to the tallies.
  function automatic model_t model_step(model_t m, logic [3:0] tt, int errmax, int tmo);
    model_t n = m;
    int k;
    if (m.mode == 1) begin
      if (v) begin
        k = {x, y};
        n.cov[k] = 1'b1;
        n.idle = 0;
        if (o != tt[k]) begin
          if (n.err < errmax) n.err = n.err + 1;
          if (!n.fev) begin n.fev = 1; n.fei = 2'(k); end
        end
        if (last) begin
          n.mode = 2;
          n.pass = (n.err == 0) && (n.cov == 4'hF);
        end
      end else begin
        n.idle = n.idle + 1;
        if (n.idle == tmo) begin n.mode = 2; n.to = 1; n.pass = 0; end
      end
    end else if (start) begin
      n = model_clear();
      n.mode = 1;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0 = model_clear();
      m1 = model_clear();
    end else begin
      m0 = model_step(m0, TT_AND, 255, 16);
      m1 = model_step(m1, TT_XOR, 3, 5);
    end
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_dut(input string tag, input model_t m, input logic busy, input logic done,
                         input logic pass, input logic to, input logic [7:0] err,
                         input logic [3:0] cov, input logic fev, input logic [1:0] fei);
    cmp({tag, "_busy"}, 32'(busy), 32'(m.mode == 1));
    cmp({tag, "_done"}, 32'(done), 32'(m.mode == 2));
    cmp({tag, "_pass"}, 32'(pass), 32'(m.pass));
    cmp({tag, "_timeout"}, 32'(to), 32'(m.to));
    cmp({tag, "_err_cnt"}, 32'(err), 32'(m.err));
    cmp({tag, "_cov"}, 32'(cov), 32'(m.cov));
    cmp({tag, "_fe_vld"}, 32'(fev), 32'(m.fev));
    cmp({tag, "_fe_idx"}, 32'(fei), 32'(m.fei));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_dut("and", m0, if0.busy, if0.done, if0.pass, if0.timeout, 8'(if0.err_cnt),
              if0.cov, if0.first_err_vld, if0.first_err_idx);
      cmp_dut("xor", m1, if1.busy, if1.done, if1.pass, if1.timeout, 8'(if1.err_cnt),
              if1.cov, if1.first_err_vld, if1.first_err_idx);
    end
  end

  // Drive one cycle of inputs at the falling edge; they are sampled at the next rising edge.
  task automatic cyc(input bit s, input bit vv, input bit xx, input bit yy, input bit oo, input bit ll);
    @(negedge clk);
    start = s; v = vv; x = xx; y = yy; o = oo; last = ll;
  endtask

  task automatic idle_cyc();
    cyc(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [3:0] tta;
    int len, gap, kk;
    bit xx, yy, vv, ll;
    tta = TT_AND;

    repeat (3) @(negedge clk);
    cmp("rst_busy", 32'(if0.busy), 32'd0);
    cmp("rst_err", 32'(if0.err_cnt), 32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    idle_cyc();

    // Clean AND run.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 0, 0);
    cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 1, 1, 1, 1, 1);
    idle_cyc();
    cmp("t1_done", 32'(if0.done), 32'd1);
    cmp("t1_pass", 32'(if0.pass), 32'd1);
    cmp("t1_cov", 32'(if0.cov), 32'hF);
    cmp("t1_err", 32'(if0.err_cnt), 32'd0);
    cmp("t1_model_pass", 32'(m0.pass), 32'd1);

    // Single mismatch on (10,1), second sample.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 1, 0);
    cyc(0, 1, 0, 1, 0, 0);
    cyc(0, 1, 1, 1, 1, 1);
    idle_cyc();
    cmp("t2_err", 32'(if0.err_cnt), 32'd1);
    cmp("t2_fev", 32'(if0.first_err_vld), 32'd1);
    cmp("t2_fei", 32'(if0.first_err_idx), 32'd2);
    cmp("t2_pass", 32'(if0.pass), 32'd0);

    // Missing index 10.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 0, 0);
    cyc(0, 1, 1, 1, 1, 1);
    idle_cyc();
    cmp("t3_cov", 32'(if0.cov), 32'hB);
    cmp("t3_pass", 32'(if0.pass), 32'd0);
    cmp("t3_err", 32'(if0.err_cnt), 32'd0);

    // Timeout 16 edges after the last sample.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 1, 1, 1, 0);
    for (int j = 1; j <= 17; j++) begin
      idle_cyc();
      if (j == 16) cmp("t4_done_early", 32'(if0.done), 32'd0);
    end
    cmp("t4_done", 32'(if0.done), 32'd1);
    cmp("t4_timeout", 32'(if0.timeout), 32'd1);
    cmp("t4_pass", 32'(if0.pass), 32'd0);

    // Five mismatches: 2-bit counter saturates; later samples in DONE are ignored.
    cyc(1, 0, 0, 0, 0, 0);
    for (int j = 0; j < 5; j++) cyc(0, 1, 0, 0, 1, j == 4);
    idle_cyc();
    cmp("t5_err_sat", 32'(if1.err_cnt), 32'd3);
    cmp("t5_err_wide", 32'(if0.err_cnt), 32'd5);
    cmp("t5_pass", 32'(if1.pass), 32'd0);
    for (int j = 0; j < 4; j++) cyc(0, 1, 1, 1, 0, 1);
    idle_cyc();
    cmp("t5_hold_err", 32'(if1.err_cnt), 32'd3);
    cmp("t5_hold_cov", 32'(if1.cov), 32'h1);
    cmp("t5_hold_done", 32'(if1.done), 32'd1);

    // Asynchronous reset mid-run after two errors, then a clean run.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 1, 0);
    cyc(0, 1, 0, 1, 1, 0);
    idle_cyc();
    cmp("t6_err_pre", 32'(if0.err_cnt), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    cmp("t6_rst_busy", 32'(if0.busy), 32'd0);
    cmp("t6_rst_err", 32'(if0.err_cnt), 32'd0);
    cmp("t6_rst_cov", 32'(if0.cov), 32'd0);
    cmp("t6_rst_fev", 32'(if0.first_err_vld), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 1, 1, 0);
    cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 1, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0, 1);
    idle_cyc();
    cmp("t6_pass", 32'(if0.pass), 32'd1);
    cmp("t6_err", 32'(if0.err_cnt), 32'd0);

    // Random runs with gaps, stray starts, errors and timeouts.
    for (int r = 0; r < 60; r++) begin
      cyc(1, 0, 0, 0, 0, 0);
      len = $urandom_range(1, 14);
      for (int i = 0; i < len; i++) begin
        xx = 1'($urandom); yy = 1'($urandom);
        vv = ($urandom % 4) != 0;
        ll = (i == len - 1) && ($urandom % 3 != 0);
        kk = {xx, yy};
        cyc(($urandom % 16) == 0, vv, xx, yy, tta[kk] ^ (($urandom % 8) == 0), ll);
      end
      gap = $urandom_range(0, 20);
      for (int i = 0; i < gap; i++)
        cyc(0, ($urandom % 6) == 0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    idle_cyc();
    idle_cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
